// File: rtl/spi_subnode_param_pkg.sv
`timescale 1ns/1ps
// Shared FSM encoding and sizing helpers for the SPI subnode.
package spi_subnode_param_pkg;

   typedef enum logic [1:0] {
      ST_CMD  = 2'd0,
      ST_WR   = 2'd1,
      ST_RD   = 2'd2,
      ST_DONE = 2'd3
   } spi_state_e;

   function automatic int unsigned max2(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/spi_shift_reg.sv
`timescale 1ns/1ps
// Shift register: parallel load and serial-in on sck rise, MSB launched on sck fall.
module spi_shift_reg #(
   parameter int unsigned W = 128
) (
   input  logic         sck_i,
   input  logic         rst_n_i,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         shift_i,
   input  logic         sin_i,
   input  logic         out_en_i,
   output logic [W-2:0] q_low_o,
   output logic         sout_o
);

   logic [W-1:0] sr_q;
   logic         sout_q;

   always_ff @(posedge sck_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         sr_q <= '0;
      end else if (load_i) begin
         sr_q <= load_val_i;
      end else if (shift_i) begin
         sr_q <= {sr_q[W-2:0], sin_i};
      end
   end

   // Idles high whenever no read is in progress.
   always_ff @(negedge sck_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         sout_q <= 1'b1;
      end else begin
         sout_q <= out_en_i ? sr_q[W-1] : 1'b1;
      end
   end

   assign q_low_o = sr_q[W-2:0];
   assign sout_o  = sout_q;

endmodule

// File: rtl/spi_subnode_param.sv
`timescale 1ns/1ps
// SPI mode-0 subnode: host-writable data/mode registers, read-only state words,
// commit-on-last-bit writes, snapshot reads and per-index write-done toggles.
module spi_subnode_param
   import spi_subnode_param_pkg::*;
#(
   parameter int unsigned NUM_REGS    = 3,
   parameter int unsigned REG_W       = 128,
   parameter int unsigned STATE_WORDS = 5,
   parameter int unsigned STATE_W     = 64,
   parameter int unsigned MODE_W      = 3,
   parameter int unsigned CMD_W       = 5
) (
   input  logic                           sck,
   input  logic                           rst_n,
   input  logic                           csb,
   input  logic                           mosi,
   output logic                           miso,
   output logic [MODE_W-1:0]              operation_mode,
   output logic [NUM_REGS*REG_W-1:0]      regs_flat,
   input  logic [STATE_WORDS*STATE_W-1:0] state_flat,
   output logic [NUM_REGS:0]              wr_toggle
);

   localparam int unsigned MODE_IDX   = NUM_REGS;
   localparam int unsigned STATE_BASE = NUM_REGS + 1;
   localparam int unsigned STATE_END  = STATE_BASE + STATE_WORDS;
   localparam int unsigned RD_BIT     = CMD_W - 1;
   localparam int unsigned SR_W       = max2(REG_W, STATE_W);
   localparam int unsigned CNT_W      = $clog2(max2(max2(SR_W, MODE_W), CMD_W));

   if (((1 << (CMD_W - 1)) < STATE_END) || (MODE_W > SR_W)) begin : g_param_check
      $error("spi_subnode_param: command index space too small for register map");
   end

   spi_state_e         state_q;
   spi_state_e         dec_state;
   logic [CNT_W-1:0]   cnt_q;
   logic [CNT_W-1:0]   dec_len_m1;
   logic [CMD_W-2:0]   cmd_q;
   logic [CMD_W-1:0]   cmd_full;
   logic [31:0]        dec_idx;
   logic [31:0]        tgt_idx;
   logic               dec_last;
   logic               frm_rst_n;
   logic               commit;
   logic [SR_W-1:0]    snap;
   logic [SR_W-2:0]    sr_low;
   logic [SR_W-1:0]    wr_data;
   logic [MODE_W-1:0]  mode_q;
   logic [NUM_REGS:0]  tog_q;

   // Frame logic is held in reset for the whole time csb is high.
   assign frm_rst_n = rst_n & ~csb;
   assign dec_last  = (state_q == ST_CMD) && (cnt_q == CNT_W'(CMD_W - 1));
   assign tgt_idx   = 32'(cmd_q);
   assign commit    = (state_q == ST_WR) && (cnt_q == '0);
   assign wr_data   = {sr_low, mosi};

   always_comb begin
      cmd_full   = {cmd_q, mosi};
      dec_idx    = 32'(cmd_full[CMD_W-2:0]);
      dec_state  = ST_DONE;
      dec_len_m1 = '0;
      snap       = '0;
      if (dec_idx < NUM_REGS) begin
         dec_state  = cmd_full[RD_BIT] ? ST_RD : ST_WR;
         dec_len_m1 = CNT_W'(REG_W - 1);
         for (int unsigned k = 0; k < NUM_REGS; k++) begin
            if (dec_idx == k) snap[SR_W-1 -: REG_W] = regs_flat[k*REG_W +: REG_W];
         end
      end else if (dec_idx == MODE_IDX) begin
         dec_state  = cmd_full[RD_BIT] ? ST_RD : ST_WR;
         dec_len_m1 = CNT_W'(MODE_W - 1);
         snap[SR_W-1 -: MODE_W] = mode_q;
      end else if (cmd_full[RD_BIT] && (dec_idx < STATE_END)) begin
         dec_state  = ST_RD;
         dec_len_m1 = CNT_W'(STATE_W - 1);
         for (int unsigned k = 0; k < STATE_WORDS; k++) begin
            if (dec_idx == STATE_BASE + k) snap[SR_W-1 -: STATE_W] = state_flat[k*STATE_W +: STATE_W];
         end
      end
   end

   always_ff @(posedge sck or negedge frm_rst_n) begin
      if (!frm_rst_n) begin
         state_q <= ST_CMD;
         cnt_q   <= '0;
         cmd_q   <= '0;
      end else begin
         unique case (state_q)
            ST_CMD: begin
               cmd_q <= cmd_full[CMD_W-2:0];
               if (dec_last) begin
                  state_q <= dec_state;
                  cnt_q   <= dec_len_m1;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            ST_WR, ST_RD: begin
               if (cnt_q == '0) state_q <= ST_DONE;
               else             cnt_q   <= cnt_q - CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

   spi_shift_reg #(.W(SR_W)) u_sr (
      .sck_i      (sck),
      .rst_n_i    (frm_rst_n),
      .load_i     (dec_last && (dec_state == ST_RD)),
      .load_val_i (snap),
      .shift_i    ((state_q == ST_WR) || (state_q == ST_RD)),
      .sin_i      (mosi),
      .out_en_i   (state_q == ST_RD),
      .q_low_o    (sr_low),
      .sout_o     (miso)
   );

   for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg
      logic [REG_W-1:0] reg_q;
      always_ff @(posedge sck or negedge rst_n) begin
         if (!rst_n)                      reg_q <= '0;
         else if (commit && tgt_idx == k) reg_q <= wr_data[REG_W-1:0];
      end
      assign regs_flat[k*REG_W +: REG_W] = reg_q;
   end

   always_ff @(posedge sck or negedge rst_n) begin
      if (!rst_n) begin
         mode_q <= '0;
         tog_q  <= '0;
      end else if (commit) begin
         if (tgt_idx == MODE_IDX) mode_q <= wr_data[MODE_W-1:0];
         for (int unsigned k = 0; k <= NUM_REGS; k++) begin
            if (tgt_idx == k) tog_q[k] <= ~tog_q[k];
         end
      end
   end

   assign operation_mode = mode_q;
   assign wr_toggle      = tog_q;

endmodule

// File: tb/tb_spi_subnode_param.sv
`timescale 1ns/1ps
// Directed bench for spi_subnode_param: table of full frames plus abort/snapshot/reset sequences.
module tb_spi_subnode_param;

   logic         sck = 1'b0;
   logic         rst_n = 1'b0;
   logic         csb = 1'b1;
   logic         mosi = 1'b0;
   logic         miso;
   logic [2:0]   operation_mode;
   logic [383:0] regs_flat;
   logic [319:0] state_flat;
   logic [3:0]   wr_toggle;

   int total = 0;
   int bad   = 0;

   localparam logic [127:0] D  = 128'h0123456789ABCDEF0123456789ABCDEF;
   localparam logic [127:0] E  = 128'hA5A5A5A55A5A5A5AFFFF00000000FFFF;
   localparam logic [127:0] F  = 128'h8000000000000001DEADBEEFCAFEF00D;
   localparam logic [127:0] G  = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
   localparam logic [63:0]  S0 = 64'h1122334455667788;
   localparam logic [63:0]  S1 = 64'h99AABBCCDDEEFF00;
   localparam logic [63:0]  S2 = 64'hCAFEBABE12345678;
   localparam logic [63:0]  S3 = 64'h0000000000000000;
   localparam logic [63:0]  S4 = 64'h0F0F0F0FA5A5A5A5;

   spi_subnode_param #(
      .NUM_REGS(3), .REG_W(128), .STATE_WORDS(5), .STATE_W(64), .MODE_W(3), .CMD_W(5)
   ) dut (
      .sck            (sck),
      .rst_n          (rst_n),
      .csb            (csb),
      .mosi           (mosi),
      .miso           (miso),
      .operation_mode (operation_mode),
      .regs_flat      (regs_flat),
      .state_flat     (state_flat),
      .wr_toggle      (wr_toggle)
   );

   always #5 sck = ~sck;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   typedef struct {
      logic [4:0]   cmd;
      int           nbits;
      logic [127:0] wdata;
      logic [127:0] exp_rd;
      logic [3:0]   exp_tog;
      logic [2:0]   exp_mode;
      logic [383:0] exp_regs;
   } vec_t;

   vec_t tbl [13];

   function automatic vec_t mk(input logic [4:0] c, input int n, input logic [127:0] w,
                               input logic [127:0] e, input logic [3:0] t, input logic [2:0] m,
                               input logic [383:0] rg);
      vec_t v;
      v.cmd = c; v.nbits = n; v.wdata = w; v.exp_rd = e;
      v.exp_tog = t; v.exp_mode = m; v.exp_regs = rg;
      return v;
   endfunction

   task automatic chk(input string name, input logic [383:0] act, input logic [383:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic start_frame();
      @(negedge sck);
      csb = 1'b0;
   endtask

   task automatic put_bit(input logic b);
      mosi = b;
      @(posedge sck);
      @(negedge sck);
   endtask

   task automatic get_bit(output logic b);
      #1;
      b = miso;
      @(posedge sck);
      @(negedge sck);
   endtask

   task automatic send_cmd(input logic [4:0] c);
      for (int i = 4; i >= 0; i--) put_bit(c[i]);
   endtask

   task automatic stop_frame();
      #1 csb = 1'b1;
      #1;
   endtask

   task automatic read_word(input int n, output logic [127:0] v);
      logic b;
      v = '0;
      for (int i = 0; i < n; i++) begin
         get_bit(b);
         v = {v[126:0], b};
      end
   endtask

   initial begin
      logic [383:0] pr_regs;
      logic [2:0]   pr_mode;
      logic [3:0]   pr_tog;
      logic [127:0] rd;
      logic         b;
      logic         ones;

      state_flat = {S4, S3, S2, S1, S0};

      tbl[0]  = mk(5'h10, 128, '0,     '0,  4'b0000, 3'd0, {128'h0, 128'h0, 128'h0});
      tbl[1]  = mk(5'h01, 128, D,      '0,  4'b0010, 3'd0, {128'h0, D, 128'h0});
      tbl[2]  = mk(5'h11, 128, '0,     D,   4'b0010, 3'd0, {128'h0, D, 128'h0});
      tbl[3]  = mk(5'h03, 3,   128'h5, '0,  4'b1010, 3'd5, {128'h0, D, 128'h0});
      tbl[4]  = mk(5'h13, 3,   '0,     128'h5, 4'b1010, 3'd5, {128'h0, D, 128'h0});
      tbl[5]  = mk(5'h02, 128, E,      '0,  4'b1110, 3'd5, {E, D, 128'h0});
      tbl[6]  = mk(5'h12, 128, '0,     E,   4'b1110, 3'd5, {E, D, 128'h0});
      tbl[7]  = mk(5'h14, 64,  '0,     {64'h0, S0}, 4'b1110, 3'd5, {E, D, 128'h0});
      tbl[8]  = mk(5'h00, 128, F,      '0,  4'b1111, 3'd5, {E, D, F});
      tbl[9]  = mk(5'h10, 128, '0,     F,   4'b1111, 3'd5, {E, D, F});
      tbl[10] = mk(5'h01, 128, G,      '0,  4'b1101, 3'd5, {E, G, F});
      tbl[11] = mk(5'h11, 128, '0,     G,   4'b1101, 3'd5, {E, G, F});
      tbl[12] = mk(5'h18, 64,  '0,     {64'h0, S4}, 4'b1101, 3'd5, {E, G, F});

      #22;
      chk("reset_regs", regs_flat, '0);
      chk("reset_mode", operation_mode, 3'd0);
      chk("reset_tog", wr_toggle, 4'b0);
      chk("reset_miso", miso, 1'b1);
      @(negedge sck);
      rst_n = 1'b1;

      pr_regs = '0; pr_mode = '0; pr_tog = '0;
      for (int r = 0; r < 13; r++) begin
         start_frame();
         send_cmd(tbl[r].cmd);
         if (tbl[r].cmd[4]) begin
            read_word(tbl[r].nbits, rd);
            chk("rd_data", rd, tbl[r].exp_rd);
         end else begin
            for (int i = 0; i < tbl[r].nbits - 1; i++) put_bit(tbl[r].wdata[tbl[r].nbits - 1 - i]);
            chk("wr_pre_regs", regs_flat, pr_regs);
            chk("wr_pre_mode", operation_mode, pr_mode);
            chk("wr_pre_tog", wr_toggle, pr_tog);
            chk("wr_miso", miso, 1'b1);
            put_bit(tbl[r].wdata[0]);
         end
         get_bit(b);
         chk("done_miso", b, 1'b1);
         chk("row_regs", regs_flat, tbl[r].exp_regs);
         chk("row_mode", operation_mode, tbl[r].exp_mode);
         chk("row_tog", wr_toggle, tbl[r].exp_tog);
         stop_frame();
         chk("idle_miso", miso, 1'b1);
         pr_regs = tbl[r].exp_regs; pr_mode = tbl[r].exp_mode; pr_tog = tbl[r].exp_tog;
      end

      // Write to reg0 aborted after 40 data bits, then a fresh read of reg0.
      start_frame();
      send_cmd(5'h00);
      for (int i = 0; i < 40; i++) put_bit(1'(i % 2));
      stop_frame();
      chk("abort_wr_regs", regs_flat, pr_regs);
      chk("abort_wr_tog", wr_toggle, pr_tog);
      start_frame();
      send_cmd(5'h10);
      read_word(128, rd);
      chk("after_abort_rd", rd, F);
      stop_frame();

      // Read of reg1 aborted while miso is driving a 0 bit.
      start_frame();
      send_cmd(5'h11);
      get_bit(b);
      get_bit(b);
      #1 chk("rd_pre_abort_miso", miso, 1'b0);
      csb = 1'b1;
      #1 chk("rd_abort_miso", miso, 1'b1);

      // S_2 changes after the snapshot: read returns old value, next read sees new one.
      start_frame();
      send_cmd(5'h16);
      get_bit(b);
      state_flat[128 +: 64] = ~S2;
      read_word(63, rd);
      chk("snap_rd", {b, rd[62:0]}, S2);
      stop_frame();
      start_frame();
      send_cmd(5'h16);
      read_word(64, rd);
      chk("snap_new_rd", rd, {64'h0, ~S2});
      stop_frame();

      // Write to a state index is dropped; miso stays high.
      start_frame();
      send_cmd(5'h04);
      ones = 1'b1;
      for (int i = 0; i < 64; i++) begin
         put_bit(1'(i % 3 == 0));
         #1 ones &= miso;
      end
      stop_frame();
      chk("ill_wr_miso", ones, 1'b1);
      chk("ill_wr_regs", regs_flat, pr_regs);
      chk("ill_wr_mode", operation_mode, pr_mode);
      chk("ill_wr_tog", wr_toggle, pr_tog);

      // Read of an out-of-range index returns all ones.
      start_frame();
      send_cmd(5'h1F);
      read_word(16, rd);
      stop_frame();
      chk("ill_rd_miso", rd, 128'hFFFF);
      chk("ill_rd_regs", regs_flat, pr_regs);

      // Reset asserted in the middle of a reg2 write.
      start_frame();
      send_cmd(5'h02);
      for (int i = 0; i < 50; i++) put_bit(1'b1);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_regs", regs_flat, '0);
      chk("rst_mid_mode", operation_mode, 3'd0);
      chk("rst_mid_tog", wr_toggle, 4'b0);
      chk("rst_mid_miso", miso, 1'b1);
      stop_frame();
      @(negedge sck);
      rst_n = 1'b1;
      start_frame();
      send_cmd(5'h12);
      read_word(128, rd);
      stop_frame();
      chk("rst_rd_reg2", rd, '0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
